// File: rtl/caseg_pkg.sv
// rtl/caseg_pkg.sv - shared types, constants and helpers for the settable clock display
// Contents:
//   set_mode_e          RUN / SET_H / SET_M / SET_S
//   HOUR_MAX, MIN_MAX   upper limits of the time fields
//   SEG_0..SEG_9, SEG_DASH, SEG_BLANK   7-segment codes in active-low form (bit7 = dp)
//   DIG_DASH, DIG_BLANK 4-bit digit codes that are not decimal digits
//   seg_decode, to_bcd, wrap_inc, wrap_dec
package caseg_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } set_mode_e;

    localparam logic [5:0] HOUR_MAX = 6'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] DIG_DASH  = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    function automatic logic [7:0] seg_decode(input logic [3:0] code);
        logic [7:0] s;
        case (code)
            4'd0:     s = SEG_0;
            4'd1:     s = SEG_1;
            4'd2:     s = SEG_2;
            4'd3:     s = SEG_3;
            4'd4:     s = SEG_4;
            4'd5:     s = SEG_5;
            4'd6:     s = SEG_6;
            4'd7:     s = SEG_7;
            4'd8:     s = SEG_8;
            4'd9:     s = SEG_9;
            DIG_DASH: s = SEG_DASH;
            default:  s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Returns {tens, units}; inputs are at most 59.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] tens;
        logic [5:0] units;
        tens  = v / 6'd10;
        units = v % 6'd10;
        return {tens[3:0], units[3:0]};
    endfunction

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
        return (v == max) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
        return (v == 6'd0) ? max : v - 6'd1;
    endfunction

endpackage

// File: rtl/caseg_clock_disp_settable_if.sv
// rtl/caseg_clock_disp_settable_if.sv - key inputs and display outputs of the settable clock
// Signals:
//   key_mode, key_up, key_down  one-cycle debounced key pulses into the clock
//   sel[NUM_DIG-1:0]            digit select, one-hot in the active polarity
//   seg[7:0]                    segments a..g (bits 0..6) and dp (bit 7)
//   set_mode[1:0]               0=RUN, 1=SET_H, 2=SET_M, 3=SET_S
// Modports: master = key source / display sink, slave = clock block.
interface caseg_clock_disp_settable_if #(
    parameter int NUM_DIG = 8
);
    logic               key_mode;
    logic               key_up;
    logic               key_down;
    logic [NUM_DIG-1:0] sel;
    logic [7:0]         seg;
    logic [1:0]         set_mode;

    modport master (
        output key_mode, key_up, key_down,
        input  sel, seg, set_mode
    );

    modport slave (
        input  key_mode, key_up, key_down,
        output sel, seg, set_mode
    );
endinterface

// File: rtl/caseg_scan.sv
// rtl/caseg_scan.sv - multiplexed 7-segment scanner: scan counter, digit mux, decode, blanking, polarity
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   digits        packed 4-bit digit codes, digit 0 in bits [3:0] (rightmost)
//   blank         per-digit blank mask (all segments off)
//   dp            per-digit decimal point request
//   sel, seg      registered digit select and segment outputs
module caseg_scan
    import caseg_pkg::*;
#(
    parameter int SCAN_DIV       = 50_000,
    parameter int NUM_DIG        = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4*NUM_DIG-1:0] digits,
    input  logic [NUM_DIG-1:0]   blank,
    input  logic [NUM_DIG-1:0]   dp,
    output logic [NUM_DIG-1:0]   sel,
    output logic [7:0]           seg
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIG);
    localparam logic [SW-1:0]      SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]      IDX_MAX  = IW'(NUM_DIG - 1);
    localparam logic [NUM_DIG-1:0] SEL_IDLE = SEL_ACTIVE_LOW ? {NUM_DIG{1'b1}} : {NUM_DIG{1'b0}};
    localparam logic [7:0]         SEG_IDLE = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [SW-1:0]      scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NUM_DIG-1:0] sel_q, sel_d;
    logic [7:0]         seg_q, seg_d;

    logic [3:0]         code;
    logic [7:0]         seg_low;
    logic [NUM_DIG-1:0] onehot;

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_MAX) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        // Output reflects the index currently held, so sel/seg move together
        // one cycle after the index itself changes.
        code    = digits[{idx_q, 2'b00} +: 4];
        seg_low = seg_decode(code);
        if (dp[idx_q]) begin
            seg_low[7] = 1'b0;
        end
        if (blank[idx_q]) begin
            seg_low = SEG_BLANK;
        end
        seg_d = SEG_ACTIVE_LOW ? seg_low : ~seg_low;

        onehot        = '0;
        onehot[idx_q] = 1'b1;
        sel_d         = SEL_ACTIVE_LOW ? ~onehot : onehot;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
            sel_q      <= SEL_IDLE;
            seg_q      <= SEG_IDLE;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule

// File: rtl/caseg_clock_disp_settable.sv
// rtl/caseg_clock_disp_settable.sv - settable 24 h clock with blinking edit field on a multiplexed 7-segment display
// Ports:
//   clk   system clock
//   rst   synchronous active-low reset
//   bus   caseg_clock_disp_settable_if.slave: key_mode/key_up/key_down in, sel/seg/set_mode out
// Optional build macro CASEG_HOUR12_EN: hour digits shown in 12 h form, hour-units dp lit for PM.
module caseg_clock_disp_settable
    import caseg_pkg::*;
#(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int SCAN_DIV       = 50_000,
    parameter int NUM_DIG        = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    caseg_clock_disp_settable_if.slave    bus
);

    generate
        if (NUM_DIG != 6 && NUM_DIG != 8) begin : g_bad_num_dig
            $error("caseg_clock_disp_settable: NUM_DIG must be 6 or 8");
        end
    endgenerate

    localparam int TW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [TW-1:0] TICK_MAX   = TW'(CLK_FREQ - 1);
    localparam logic [TW-1:0] BLINK_HALF = TW'(CLK_FREQ / 2);

    // Position of the units digit of each field; the tens digit sits one above.
    localparam int H_POS = (NUM_DIG == 8) ? 6 : 4;
    localparam int M_POS = (NUM_DIG == 8) ? 3 : 2;
    localparam int S_POS = 0;

    set_mode_e     state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [TW-1:0] blink_cnt_q, blink_cnt_d;
    logic [4:0]    hour_q, hour_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;

    logic tick;
    logic step_up;
    logic step_dn;

    always_comb begin
        tick        = (state_q == RUN) && (tick_cnt_q == TICK_MAX);
        // Held at zero while editing so RUN always restarts a full second.
        tick_cnt_d  = (state_q != RUN || tick) ? '0 : tick_cnt_q + 1'b1;
        blink_cnt_d = (blink_cnt_q == TICK_MAX) ? '0 : blink_cnt_q + 1'b1;

        // key_mode wins over up/down; opposing keys cancel.
        step_up = bus.key_up & ~bus.key_down & ~bus.key_mode;
        step_dn = bus.key_down & ~bus.key_up & ~bus.key_mode;

        state_d = state_q;
        if (bus.key_mode) begin
            case (state_q)
                RUN:     state_d = SET_H;
                SET_H:   state_d = SET_M;
                SET_M:   state_d = SET_S;
                default: state_d = RUN;
            endcase
        end

        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        case (state_q)
            RUN: begin
                if (tick) begin
                    sec_d = wrap_inc(sec_q, MIN_MAX);
                    if (sec_q == MIN_MAX) begin
                        min_d = wrap_inc(min_q, MIN_MAX);
                        if (min_q == MIN_MAX) begin
                            hour_d = 5'(wrap_inc({1'b0, hour_q}, HOUR_MAX));
                        end
                    end
                end
            end
            SET_H: begin
                if (step_up) hour_d = 5'(wrap_inc({1'b0, hour_q}, HOUR_MAX));
                if (step_dn) hour_d = 5'(wrap_dec({1'b0, hour_q}, HOUR_MAX));
            end
            SET_M: begin
                if (step_up) min_d = wrap_inc(min_q, MIN_MAX);
                if (step_dn) min_d = wrap_dec(min_q, MIN_MAX);
            end
            default: begin
                if (step_up) sec_d = wrap_inc(sec_q, MIN_MAX);
                if (step_dn) sec_d = wrap_dec(sec_q, MIN_MAX);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            tick_cnt_q  <= '0;
            blink_cnt_q <= '0;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
        end
    end

    // Display formatting
    logic [4:0]         hour_disp;
    logic               pm;
    logic [7:0]         h_bcd;
    logic [7:0]         m_bcd;
    logic [7:0]         s_bcd;
    logic [4*NUM_DIG-1:0] digits;
    logic [NUM_DIG-1:0] blank;
    logic [NUM_DIG-1:0] dp;
    logic               blink_off;

    always_comb begin
`ifdef CASEG_HOUR12_EN
        if (hour_q == 5'd0) begin
            hour_disp = 5'd12;
        end else if (hour_q > 5'd12) begin
            hour_disp = hour_q - 5'd12;
        end else begin
            hour_disp = hour_q;
        end
        pm = (hour_q >= 5'd12);
`else
        hour_disp = hour_q;
        pm        = 1'b0;
`endif
        h_bcd = to_bcd({1'b0, hour_disp});
        m_bcd = to_bcd(min_q);
        s_bcd = to_bcd(sec_q);

        blink_off = (blink_cnt_q >= BLINK_HALF);
        blank     = '0;
        if (blink_off) begin
            case (state_q)
                SET_H:   blank[H_POS +: 2] = 2'b11;
                SET_M:   blank[M_POS +: 2] = 2'b11;
                SET_S:   blank[S_POS +: 2] = 2'b11;
                default: blank = '0;
            endcase
        end

        dp        = '0;
        dp[H_POS] = pm;
    end

    generate
        if (NUM_DIG == 8) begin : g_layout8
            assign digits = {h_bcd, DIG_DASH, m_bcd, DIG_DASH, s_bcd};
        end else begin : g_layout6
            assign digits = {h_bcd, m_bcd, s_bcd};
        end
    endgenerate

    caseg_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .NUM_DIG        (NUM_DIG),
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW),
        .SEL_ACTIVE_LOW (SEL_ACTIVE_LOW)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .digits (digits),
        .blank  (blank),
        .dp     (dp),
        .sel    (bus.sel),
        .seg    (bus.seg)
    );

    assign bus.set_mode = state_q;

endmodule

// File: tb/tb_caseg_clock_disp_settable.sv
// tb/tb_caseg_clock_disp_settable.sv - self-checking bench for caseg_clock_disp_settable
module tb_caseg_clock_disp_settable;

    localparam int CF = 10;
    localparam int SD = 2;
    localparam int ND = 8;

    localparam logic [7:0] GLYPH [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic clk = 1'b0;
    logic rst = 1'b0;

    caseg_clock_disp_settable_if #(.NUM_DIG(ND)) bus ();

    caseg_clock_disp_settable #(
        .CLK_FREQ       (CF),
        .SCAN_DIV       (SD),
        .NUM_DIG        (ND),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: wall-clock time, edit mode, cycles since reset, RUN cycles since last tick.
    int m_h = 0;
    int m_m = 0;
    int m_s = 0;
    int m_mode = 0;
    int m_cyc = 0;
    int m_run = 0;

    logic [7:0] disp [ND];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_seg(input int idx);
        int v;
        bit blanked;
        v = -1;
        case (idx)
            0: v = m_s % 10;
            1: v = m_s / 10;
            3: v = m_m % 10;
            4: v = m_m / 10;
            6: v = m_h % 10;
            7: v = m_h / 10;
            default: v = -1;
        endcase
        blanked = 1'b0;
        if (m_mode != 0 && (m_cyc % CF) >= CF / 2) begin
            if (m_mode == 1 && idx >= 6) blanked = 1'b1;
            if (m_mode == 2 && (idx == 3 || idx == 4)) blanked = 1'b1;
            if (m_mode == 3 && idx <= 1) blanked = 1'b1;
        end
        if (blanked) return 8'hFF;
        if (v < 0) return 8'hBF;
        return GLYPH[v];
    endfunction

    task automatic step();
        logic [7:0] e_sel;
        logic [7:0] e_seg;
        int idx;
        int tot;
        int dir;
        @(posedge clk);
        if (!rst) begin
            e_sel = 8'hFF;
            e_seg = 8'hFF;
            m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_cyc = 0; m_run = 0;
        end else begin
            idx   = (m_cyc / SD) % ND;
            e_sel = ~(8'(1) << idx);
            e_seg = exp_seg(idx);
            if (m_mode == 0) begin
                if (m_run == CF - 1) begin
                    m_run = 0;
                    tot = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                    m_h = tot / 3600;
                    m_m = (tot / 60) % 60;
                    m_s = tot % 60;
                end else begin
                    m_run++;
                end
            end else begin
                m_run = 0;
            end
            dir = 0;
            if (!bus.key_mode && bus.key_up && !bus.key_down) dir = 1;
            if (!bus.key_mode && bus.key_down && !bus.key_up) dir = -1;
            if (dir != 0) begin
                if (m_mode == 1) m_h = (m_h + dir + 24) % 24;
                if (m_mode == 2) m_m = (m_m + dir + 60) % 60;
                if (m_mode == 3) m_s = (m_s + dir + 60) % 60;
            end
            if (bus.key_mode) m_mode = (m_mode + 1) % 4;
            m_cyc++;
        end
        #1;
        check("sel", 32'(bus.sel), 32'(e_sel));
        check("seg", 32'(bus.seg), 32'(e_seg));
        check("set_mode", 32'(bus.set_mode), 32'(m_mode));
    endtask

    task automatic pulse(input bit km, input bit ku, input bit kd);
        bus.key_mode = km;
        bus.key_up   = ku;
        bus.key_down = kd;
        step();
        bus.key_mode = 1'b0;
        bus.key_up   = 1'b0;
        bus.key_down = 1'b0;
    endtask

    task automatic capture();
        for (int c = 0; c < 2 * SD * ND; c++) begin
            step();
            for (int i = 0; i < ND; i++) begin
                if (bus.sel[i] == 1'b0) disp[i] = bus.seg;
            end
        end
    endtask

    initial begin
        bus.key_mode = 1'b0;
        bus.key_up   = 1'b0;
        bus.key_down = 1'b0;
        for (int i = 0; i < ND; i++) disp[i] = 8'h00;

        // Reset state
        rst = 1'b0;
        repeat (3) step();
        check("rst_sel", 32'(bus.sel), 32'h0FF);
        check("rst_seg", 32'(bus.seg), 32'h0FF);
        check("rst_mode", 32'(bus.set_mode), 32'd0);
        rst = 1'b1;
        step();
        check("first_sel", 32'(bus.sel), 32'h0FE);
        check("first_seg", 32'(bus.seg), 32'h0C0);

        // Set 23:59:59 and roll over
        pulse(1, 0, 0);
        check("mode_set_h", 32'(bus.set_mode), 32'd1);
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        check("mode_run", 32'(bus.set_mode), 32'd0);
        repeat (CF) step();

        // Freeze in SET_M, then read non-edited digits
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        check("mode_set_m", 32'(bus.set_mode), 32'd2);
        repeat (30) step();
        capture();
        check("roll_su", 32'(disp[0]), 32'h0C0);
        check("roll_st", 32'(disp[1]), 32'h0C0);
        check("dash_2", 32'(disp[2]), 32'h0BF);
        check("dash_5", 32'(disp[5]), 32'h0BF);
        check("roll_hu", 32'(disp[6]), 32'h0C0);
        check("roll_ht", 32'(disp[7]), 32'h0C0);

        // Hour edit wrap and key collisions
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        check("mode_set_h2", 32'(bus.set_mode), 32'd1);
        pulse(0, 0, 1);
        pulse(0, 1, 0);
        pulse(0, 1, 1);
        pulse(1, 1, 0);
        check("mode_collide", 32'(bus.set_mode), 32'd2);
        pulse(1, 0, 0);
        pulse(1, 0, 0);

        // Running display after a few seconds
        repeat (3 * CF) step();
        capture();
        check("run_dash_2", 32'(disp[2]), 32'h0BF);

        // Reset mid-edit
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        check("mode_set_s", 32'(bus.set_mode), 32'd3);
        pulse(0, 1, 0);
        rst = 1'b0;
        step();
        check("midrst_mode", 32'(bus.set_mode), 32'd0);
        check("midrst_seg", 32'(bus.seg), 32'h0FF);
        rst = 1'b1;
        repeat (2 * CF + 5) step();

        // Randomized keys with occasional resets
        for (int n = 0; n < 4000; n++) begin
            rst          = ($urandom_range(0, 299) != 0);
            bus.key_mode = ($urandom_range(0, 19) == 0);
            bus.key_up   = ($urandom_range(0, 3) == 0);
            bus.key_down = ($urandom_range(0, 3) == 0);
            step();
        end
        rst          = 1'b1;
        bus.key_mode = 1'b0;
        bus.key_up   = 1'b0;
        bus.key_down = 1'b0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
